// File: rtl/bin2bcd_ci.sv
// bin2bcd_ci: multicycle Nios II custom instruction that converts a 32-bit
// unsigned binary operand into 8-digit packed BCD using sequential
// double-dabble. Each input bit takes one ADJUST edge and one SHIFT edge.
// The handshake is clk_en / start / done / result.
// Inputs of 100_000_000 and above saturate to all nines. The conversion
// still runs the full sequence, so latency is the same for every input.
//
// Optional feature, enabled by defining BCD_BLANK_EN: leading zero digits
// 7..1 are replaced by BLANK_CODE in the final result.
module bin2bcd_ci #(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADJUST,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam logic [31:0] MAX_BCD_VALUE = 32'd99_999_999;
  localparam logic [31:0] SAT_PATTERN   = 32'h9999_9999;
  localparam logic [5:0]  LAST_BIT      = 6'd31;

  state_t      state_q, state_d;
  logic [63:0] shift_q, shift_d;   // {BCD field, binary field}
  logic [5:0]  cnt_q,   cnt_d;
  logic        sat_q,   sat_d;
  logic [31:0] result_q, result_d;
  logic        done_q,  done_d;
  logic [31:0] bcd_out;

`ifdef BCD_BLANK_EN
  logic        leading;

  // Final digit formatting: blank leading zeros from digit 7 down to digit 1.
  always_comb begin
    bcd_out = shift_q[63:32];
    leading = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (leading && (bcd_out[4*i +: 4] == 4'd0)) begin
        bcd_out[4*i +: 4] = BLANK_CODE;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  // datab and BLANK_CODE are not needed in this build.
  logic unused_inputs;
  assign unused_inputs = ^{datab, BLANK_CODE};

  // Final digit formatting: raw packed BCD.
  always_comb begin
    bcd_out = shift_q[63:32];
  end
`endif

`ifdef BCD_BLANK_EN
  // datab is not part of the operation.
  logic unused_datab;
  assign unused_datab = ^datab;
`endif

  // Next-state and datapath logic for the double-dabble sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    result_d = result_q;
    done_d   = done_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          shift_d = {32'd0, dataa};
          cnt_d   = 6'd0;
          sat_d   = (dataa > MAX_BCD_VALUE);
          state_d = S_ADJUST;
        end
      end

      S_ADJUST: begin
        // Each BCD digit >= 5 gets +3 with no carry into the next digit.
        for (int i = 0; i < 8; i++) begin
          if (shift_q[32 + 4*i +: 4] >= 4'd5) begin
            shift_d[32 + 4*i +: 4] = shift_q[32 + 4*i +: 4] + 4'd3;
          end
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        shift_d = {shift_q[62:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == LAST_BIT) ? S_FINISH : S_ADJUST;
      end

      S_FINISH: begin
        result_d = sat_q ? SAT_PATTERN : bcd_out;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers: asynchronous reset, frozen whenever clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= 64'd0;
      cnt_q    <= 6'd0;
      sat_q    <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      // NOTE: non-blocking assignments let every register sample the same pre-edge values.
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bin2bcd_ci.sv
// tb_bin2bcd_ci: directed-vector bench for bin2bcd_ci. Expected results are
// hand-computed constants, with alternatives for a BCD_BLANK_EN build.
// Inputs change on the falling edge. Outputs are sampled 1 ns after the
// rising edge.
module tb_bin2bcd_ci;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef BCD_BLANK_EN
  localparam logic [31:0] EXP_0    = 32'hFFFF_FFF0;
  localparam logic [31:0] EXP_907  = 32'hFFFF_F907;
  localparam logic [31:0] EXP_4096 = 32'hFFFF_4096;
  localparam logic [31:0] EXP_42   = 32'hFFFF_FF42;
`else
  localparam logic [31:0] EXP_0    = 32'h0000_0000;
  localparam logic [31:0] EXP_907  = 32'h0000_0907;
  localparam logic [31:0] EXP_4096 = 32'h0000_4096;
  localparam logic [31:0] EXP_42   = 32'h0000_0042;
`endif

  bin2bcd_ci dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one conversion and checks latency, result and the done pulse.
  //   poke_edge  : if nonzero, a stray start with dataa=5 is sampled on this enabled edge
  //   stall_edge : clk_en is dropped after this many enabled edges ...
  //   stall_len  : ... for this many cycles (0 = no stall)
  //   done_hold  : cycles to hold clk_en low while done is high (0 = none)
  task automatic conv(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input int poke_edge, input int stall_edge, input int stall_len,
                      input int done_hold);
    int  en_edges;
    int  total;
    int  stalled;
    bit  found;
    bit  extra_done;
    @(negedge clk);
    dataa    = a;
    start    = 1'b1;
    clk_en   = 1'b1;
    en_edges = 0;
    total    = 0;
    stalled  = 0;
    found    = 1'b0;
    while (!found && total < 300) begin
      @(posedge clk);
      total++;
      if (clk_en) en_edges++;
      #1;
      if (done) found = 1'b1;
      @(negedge clk);
      start = (poke_edge != 0) && (en_edges == poke_edge - 1);
      if (start) dataa = 32'd5;
      if (stall_len > 0 && en_edges == stall_edge && stalled < stall_len) begin
        clk_en = 1'b0;
        stalled++;
      end else begin
        clk_en = 1'b1;
      end
    end
    check({tag, " latency"}, 64'(en_edges), 64'd66);
    check({tag, " cycles"}, 64'(total), 64'(66 + stall_len));
    check({tag, " result"}, 64'(result), 64'(exp));
    if (done_hold > 0) begin
      clk_en = 1'b0;
      repeat (done_hold) begin
        @(posedge clk);
        #1;
        check({tag, " done frozen"}, 64'(done), 64'd1);
      end
      @(negedge clk);
      clk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    if (poke_edge != 0) begin
      extra_done = 1'b0;
      repeat (80) begin
        @(posedge clk);
        #1;
        if (done) extra_done = 1'b1;
      end
      check({tag, " no second done"}, 64'(extra_done), 64'd0);
      check({tag, " result held"}, 64'(result), 64'(exp));
    end
  endtask

  initial begin
    bit stray_done;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'd0;
    datab  = 32'hDEAD_BEEF;
    #1;
    check("reset result", 64'(result), 64'd0);
    check("reset done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    conv("12345678", 32'd12_345_678, 32'h1234_5678, 0, 0, 0, 0);
    conv("zero", 32'd0, EXP_0, 0, 0, 0, 0);
    conv("99999999", 32'd99_999_999, 32'h9999_9999, 0, 0, 0, 0);
    conv("sat 1e8", 32'd100_000_000, 32'h9999_9999, 0, 0, 0, 0);
    conv("sat max", 32'hFFFF_FFFF, 32'h9999_9999, 0, 0, 0, 0);
    conv("907 poke", 32'd907, EXP_907, 10, 0, 0, 0);
    conv("4096 stall", 32'd4_096, EXP_4096, 0, 20, 20, 5);

    // Abort a conversion with an asynchronous reset just after edge 30.
    @(negedge clk);
    dataa = 32'd12_345_678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort result", 64'(result), 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray_done = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) stray_done = 1'b1;
    end
    check("abort no done", 64'(stray_done), 64'd0);
    check("abort result held", 64'(result), 64'd0);

    conv("42 after reset", 32'd42, EXP_42, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
